tap_counter: RTL and testbench
==============================

Name: tap_counter

Overview:
- Counts discrete user taps on a mechanical push-button and presents the running total as a 7-bit binary value.
- Feeds the two-digit seven-segment display path; downstream logic splits the value into tens and units.
- Contains an input synchronizer, a debounce filter, press-edge detection and a modulo-100 counter.

Parameters:
- DEBOUNCE_CYCLES, 240000, clk cycles the synchronized input must hold a new level before it is accepted (20 ms at 12 MHz); legal range 1 to 2^24-1.
- MAX_COUNT, 99, highest value of times; the next press wraps to 0; legal range 1 to 127.
- TAP_ACTIVE_LOW, 1, 1 means tap=0 is pressed; 0 means tap=1 is pressed.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately and is released synchronously by the system.
- tap  input  1  raw, asynchronous, bouncing push-button level.
- times  output  7  registered tap count, 0..MAX_COUNT.

Behaviour:
- Reset (rst=1, asynchronous):
  - times=0, debounce counter=0.
  - Both synchronizer flops and the debounced state are forced to the released level (1 if TAP_ACTIVE_LOW else 0).
- Synchronizer:
  - Two flops in series; s2 is the synchronized level.
  - 2-cycle latency from tap to s2.
- Debounce:
  - Register stable holds the accepted level.
  - While s2==stable, the debounce counter is held at 0.
  - While s2!=stable, the counter increments each cycle.
  - When s2!=stable and the counter equals DEBOUNCE_CYCLES-1, stable<=s2 and the counter clears.
  - Any reversion of s2 before that point clears the counter; glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
  - The counter width is sized from DEBOUNCE_CYCLES.
- Press detect:
  - A one-cycle press pulse occurs in the cycle stable changes from released to pressed.
  - A release (pressed to released) produces no count.
- Counter:
  - On a press pulse: if times==MAX_COUNT, times<=0; else times<=times+1.
  - times changes exactly one cycle after the press pulse.
  - Total latency from a clean tap edge to the times update is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Holding the button produces exactly one count, however long it is held.
- A new count requires a debounced release followed by a debounced press.
- Reset mid-operation:
  - All state returns to reset values at once.
  - If the button is still held when rst deasserts, it is treated as a new press: one count after the normal debounce latency.
- times never exceeds MAX_COUNT.
- times is glitch-free (driven directly from a flop).

Test Plan (DEBOUNCE_CYCLES=4, MAX_COUNT=99, TAP_ACTIVE_LOW=1):
- Reset: assert rst with tap=1 -> times=0 immediately (asynchronous), no change after rst release while tap stays 1.
- Clean tap: drive tap=0 for 20 cycles, then tap=1 -> times goes 0->1 exactly 7 cycles after the falling edge; stays 1 after release.
- Bounce: toggle tap every 2 cycles for 12 cycles, then hold tap=0 for 10 cycles and release -> times increments by exactly 1.
- Long hold: tap=0 for 200 cycles -> single increment; a release then re-press -> second increment (times=2).
- Wrap: apply 100 clean taps from reset -> times reads 99 after the 99th tap and 0 after the 100th.
- Reset mid-press: with times=5 and tap held at 0, pulse rst for 1 cycle mid-cycle -> times=0 asynchronously; 7 cycles after release times=1.

Source files
------------

// File: rtl/tap_counter.sv
// tap_counter: counts debounced presses of a mechanical push-button.
// Chain: two-flop synchronizer -> debounce filter -> press-edge pulse ->
// modulo-(MAX_COUNT+1) counter. The count is always driven from a flop.
module tap_counter #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int MAX_COUNT       = 99,
    parameter bit TAP_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tap,
    output logic [6:0] times
);

    // Level the button rests at, and the level it shows while held.
    localparam logic REL_LEVEL = TAP_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic PRS_LEVEL = TAP_ACTIVE_LOW ? 1'b0 : 1'b1;

    // The debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [6:0] TIMES_MAX  = 7'(MAX_COUNT);
    localparam logic [6:0] TIMES_ZERO = 7'd0;
    localparam logic [6:0] TIMES_ONE  = 7'd1;

    // Next count value; any value at or above the maximum (including a
    // corrupted one) returns to zero so the output never leaves range.
    function automatic logic [6:0] next_count(input logic [6:0] cur);
        logic [6:0] res;
        if (cur >= TIMES_MAX) begin
            res = TIMES_ZERO;
        end else begin
            res = cur + TIMES_ONE;
        end
        return res;
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;
    logic [6:0]       times_r;

    logic             differ_s;
    logic             accept_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stable_nxt_s;
    logic             press_nxt_s;
    logic [6:0]       times_nxt_s;

    // Bring the raw asynchronous button level into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= REL_LEVEL;
            sync2_r <= REL_LEVEL;
        end else begin
            sync1_r <= tap;
            sync2_r <= sync1_r;
        end
    end

    // Debounce decision: count how long the synchronized level has
    // disagreed with the accepted level and accept it once it has held.
    always_comb begin
        differ_s     = 1'b0;
        accept_s     = 1'b0;
        cnt_nxt_s    = CNT_ZERO;
        stable_nxt_s = stable_r;
        press_nxt_s  = 1'b0;

        differ_s = (sync2_r != stable_r);
        accept_s = differ_s && (cnt_r == CNT_LAST);

        if (!differ_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (accept_s) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end

        if (accept_s) begin
            stable_nxt_s = sync2_r;
        end else begin
            stable_nxt_s = stable_r;
        end

        // Only a released-to-pressed acceptance is a press; releases
        // produce no pulse.
        if (accept_s && (sync2_r == PRS_LEVEL)) begin
            press_nxt_s = 1'b1;
        end else begin
            press_nxt_s = 1'b0;
        end
    end

    // Debounce state and the one-cycle press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= CNT_ZERO;
            stable_r <= REL_LEVEL;
            press_r  <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            stable_r <= stable_nxt_s;
            press_r  <= press_nxt_s;
        end
    end

    // Advance the tap count on each press pulse, wrapping after the maximum.
    always_comb begin
        times_nxt_s = times_r;
        if (press_r) begin
            times_nxt_s = next_count(times_r);
        end else begin
            times_nxt_s = times_r;
        end
    end

    // Tap count register; drives the output directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            times_r <= TIMES_ZERO;
        end else begin
            times_r <= times_nxt_s;
        end
    end

    assign times = times_r;

endmodule

// File: tb/tb_tap_counter.sv
// tb_tap_counter: scoreboard bench for tap_counter with a short debounce.
// Each accepted press pushes {expected count, expected cycle} to a queue;
// a monitor pops an entry whenever times changes and checks both.
module tb_tap_counter;

    localparam int DEB = 4;
    localparam int MAXC = 99;
    localparam int LAT = 2 + DEB + 1;

    logic       clk;
    logic       rst;
    logic       tap;
    logic [6:0] times;

    tap_counter #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_COUNT      (MAXC),
        .TAP_ACTIVE_LOW (1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tap  (tap),
        .times(times)
    );

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         cyc;
    int         exp_count;
    int         n_checks;
    int         n_pass;
    logic [6:0] prev_times;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, advanced on each active edge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks = n_checks + 1;
        if (obs == expv) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Record that the press just driven must show up LAT cycles from now.
    task automatic push_press();
        exp_t e;
        exp_count = (exp_count == MAXC) ? 0 : exp_count + 1;
        e.val = exp_count;
        e.cyc = cyc + LAT;
        sb_q.push_back(e);
    endtask

    // Compare every change of times against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rst) begin
            prev_times <= 7'd0;
        end else begin
            if (times != prev_times) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_change", int'(times), int'(prev_times));
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("value", int'(times), mon_e.val);
                    chk("latency", cyc, mon_e.cyc);
                end
            end
            prev_times <= times;
        end
    end

    // Asynchronous reset pulse starting mid-cycle; a held button at release
    // counts as a new press.
    task automatic do_reset(input int hold_cycles);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", int'(times), 0);
        sb_q.delete();
        exp_count = 0;
        repeat (hold_cycles) @(negedge clk);
        #2 rst = 1'b0;
        if (tap == 1'b0) begin
            push_press();
        end
    endtask

    task automatic press(input int hold, input int rel);
        @(negedge clk);
        tap = 1'b0;
        push_press();
        repeat (hold) @(negedge clk);
        tap = 1'b1;
        repeat (rel) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        exp_count = 0;
        rst = 1'b0;
        tap = 1'b1;
        prev_times = 7'd0;

        // Reset with the button released; nothing changes afterwards.
        do_reset(3);
        repeat (20) @(negedge clk);
        chk("idle_after_reset", int'(times), 0);

        // Single clean tap.
        press(20, 20);
        chk("clean_tap", int'(times), 1);

        // Bouncing contact, then a solid hold: exactly one count.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tap = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        tap = 1'b0;
        push_press();
        repeat (10) @(negedge clk);
        tap = 1'b1;
        repeat (20) @(negedge clk);
        chk("bounce", int'(times), 2);

        // Long hold counts once; release and re-press counts again.
        do_reset(2);
        press(200, 20);
        chk("long_hold", int'(times), 1);
        press(15, 20);
        chk("repress", int'(times), 2);

        // Wrap after the maximum.
        do_reset(2);
        for (int i = 1; i <= 100; i++) begin
            press(10, 10);
            if (i == 99) chk("wrap_99", int'(times), 99);
            if (i == 100) chk("wrap_0", int'(times), 0);
        end

        // Reset while the button is held: zero at once, then one count.
        do_reset(2);
        for (int i = 0; i < 4; i++) press(10, 10);
        @(negedge clk);
        tap = 1'b0;
        push_press();
        repeat (20) @(negedge clk);
        chk("held_count", int'(times), 5);
        do_reset(1);
        repeat (20) @(negedge clk);
        tap = 1'b1;
        repeat (20) @(negedge clk);
        chk("reset_mid_press", int'(times), 1);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
